mips_mc_controller: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 37 +++
 rtl/mips_mc_controller_if.sv | 35 +++
 rtl/mips_alu_dec.sv | 37 +++
 rtl/mips_mc_controller.sv | 150 +++++++++++++++
 tb/tb_mips_mc_controller.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// opcodes, functs, ALU operations and FSM states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE,
    S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_REX, S_RWB, S_BR,
    S_IEX, S_IWB, S_JMP
  } state_e;

  typedef enum logic [1:0] {
    CLS_ADD, CLS_SUB, CLS_FUNCT, CLS_IMM
  } alu_cls_e;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and
// zero flag in, enables/selects/ALU op out.
interface mips_mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;

  modport ctrl (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite,
    output regdst, memtoreg, regwrite,
    output alusrca, alusrcb, pcsrc,
    output alucontrol, illegal
  );

  modport dp (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite,
    input  regdst, memtoreg, regwrite,
    input  alusrca, alusrcb, pcsrc,
    input  alucontrol, illegal
  );
endinterface

// File: rtl/mips_alu_dec.sv
// ALU operation decoder: the FSM picks a class, this maps
// class + op + funct to alucontrol and flags legal functs.
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  alu_cls_e   cls,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_valid
);

  always_comb begin
    alucontrol  = ALU_ADD;
    funct_valid = 1'b0;
    unique case (cls)
      CLS_ADD: alucontrol = ALU_ADD;
      CLS_SUB: alucontrol = ALU_SUB;
      CLS_IMM: begin
        if (op == OP_SLTI) alucontrol = ALU_SLT;
      end
      CLS_FUNCT: begin
        funct_valid = 1'b1;
        unique case (1'b1)
          (funct == F_ADD): alucontrol = ALU_ADD;
          (funct == F_SUB): alucontrol = ALU_SUB;
          (funct == F_AND): alucontrol = ALU_AND;
          (funct == F_OR):  alucontrol = ALU_OR;
          (funct == F_SLT): alucontrol = ALU_SLT;
          default:          funct_valid = 1'b0;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: Moore outputs per state,
// pcen additionally folds in the branch zero test.
module mips_mc_controller
  import mips_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  mips_mc_controller_if.ctrl bus
);

  state_e     state_q, state_d;
  alu_cls_e   alu_cls;
  logic       funct_valid;
  logic [2:0] alucontrol;
  logic       pcwrite, branch, bne_sel;
  logic       iord, memwrite, irwrite;
  logic       regdst, memtoreg, regwrite;
  logic       alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;

  mips_alu_dec u_alu_dec (
    .cls         (alu_cls),
    .op          (bus.op),
    .funct       (bus.funct),
    .alucontrol  (alucontrol),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_RST;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    alu_cls  = CLS_ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    bne_sel  = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'd0;
    pcsrc    = 2'd0;
    illegal  = 1'b0;
    unique case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'd1;
        pcwrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'd3;
        unique case (1'b1)
          (bus.op == OP_LW),
          (bus.op == OP_SW):   state_d = S_MEMADR;
          (bus.op == OP_RTYPE): state_d = S_REX;
          (bus.op == OP_BEQ),
          (bus.op == OP_BNE):  state_d = S_BR;
          (bus.op == OP_ADDI),
          (bus.op == OP_SLTI): state_d = S_IEX;
          (bus.op == OP_J):    state_d = S_JMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
        state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_REX: begin
        alusrca = 1'b1;
        alu_cls = CLS_FUNCT;
        // Bad funct aborts before writeback
        if (funct_valid) begin
          state_d = S_RWB;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BR: begin
        alusrca = 1'b1;
        alu_cls = CLS_SUB;
        pcsrc   = 2'd1;
        branch  = 1'b1;
        bne_sel = (bus.op == OP_BNE);
        state_d = S_FETCH;
      end
      S_IEX: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
        alu_cls = CLS_IMM;
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JMP: begin
        pcsrc   = 2'd2;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_RST;
    endcase
  end

  assign bus.pcen       = pcwrite | (branch & (bus.zero ^ bne_sel));
  assign bus.iord       = iord;
  assign bus.memwrite   = memwrite;
  assign bus.irwrite    = irwrite;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.regwrite   = regwrite;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.illegal    = illegal;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: per-cycle output vectors
// compared against an instruction-level timing model.
module tb_mips_mc_controller;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  mips_mc_controller_if bus ();

  mips_mc_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.ctrl)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] RST_VEC = 16'h0004;

  function automatic logic [15:0] mk(
    input logic pcen, iord, mw, irw, rd, mtr, rw, asa,
    input logic [1:0] asb, pcs,
    input logic [2:0] alu,
    input logic ill
  );
    return {pcen, iord, mw, irw, rd, mtr, rw, asa,
            asb, pcs, alu, ill};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.pcen, bus.iord, bus.memwrite, bus.irwrite,
            bus.regdst, bus.memtoreg, bus.regwrite,
            bus.alusrca, bus.alusrcb, bus.pcsrc,
            bus.alucontrol, bus.illegal};
  endfunction

  function automatic logic op_known(input logic [5:0] op);
    return op inside {6'h23, 6'h2b, 6'h00, 6'h04,
                      6'h05, 6'h08, 6'h0a, 6'h02};
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return {1'b1, 3'd2};
      6'h22:   return {1'b1, 3'd6};
      6'h24:   return {1'b1, 3'd0};
      6'h25:   return {1'b1, 3'd1};
      6'h2a:   return {1'b1, 3'd7};
      default: return {1'b0, 3'd2};
    endcase
  endfunction

  function automatic int cpi(input logic [5:0] op,
                             input logic [5:0] fn);
    logic [3:0] r;
    r = r_alu(fn);
    case (op)
      6'h23:               return 5;
      6'h2b, 6'h08, 6'h0a: return 4;
      6'h00:               return r[3] ? 4 : 3;
      6'h04, 6'h05, 6'h02: return 3;
      default:             return 2;
    endcase
  endfunction

  // Expected outputs in cycle k of an instruction (k=0 is FETCH)
  function automatic logic [15:0] model_vec(
    input logic [5:0] op, fn, input logic z, input int k
  );
    logic [3:0] r;
    r = r_alu(fn);
    if (k == 0) return mk(1,0,0,1,0,0,0,0,2'd1,2'd0,3'd2,0);
    if (k == 1)
      return mk(0,0,0,0,0,0,0,0,2'd3,2'd0,3'd2,!op_known(op));
    case (op)
      6'h23, 6'h2b: begin
        if (k == 2) return mk(0,0,0,0,0,0,0,1,2'd2,2'd0,3'd2,0);
        if (k == 3)
          return mk(0,1,op == 6'h2b,0,0,0,0,0,2'd0,2'd0,3'd2,0);
        return mk(0,0,0,0,0,1,1,0,2'd0,2'd0,3'd2,0);
      end
      6'h00: begin
        if (k == 2) return mk(0,0,0,0,0,0,0,1,2'd0,2'd0,r[2:0],!r[3]);
        return mk(0,0,0,0,1,0,1,0,2'd0,2'd0,3'd2,0);
      end
      6'h04, 6'h05:
        return mk((op == 6'h04) ? z : !z,0,0,0,0,0,0,1,
                  2'd0,2'd1,3'd6,0);
      6'h08, 6'h0a: begin
        if (k == 2)
          return mk(0,0,0,0,0,0,0,1,2'd2,2'd0,
                    (op == 6'h0a) ? 3'd7 : 3'd2,0);
        return mk(0,0,0,0,0,0,1,0,2'd0,2'd0,3'd2,0);
      end
      6'h02: return mk(1,0,0,0,0,0,0,0,2'd0,2'd2,3'd2,0);
      default: return RST_VEC;
    endcase
  endfunction

  task automatic test_reset();
    logic [15:0] got;
    for (int i = 0; i < 3; i++) begin
      bus.op = 6'($urandom);
      bus.funct = 6'($urandom);
      bus.zero = 1'($urandom);
      if (i == 2) reset_n = 1'b1;
      @(negedge clk);
      got = obs();
      n_checks++;
      if (got !== RST_VEC) begin
        n_errors++;
        $display("FAIL reset i=%0d got=%h exp=%h", i, got, RST_VEC);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    logic [15:0] got, exp;
    bus.op = 6'h23;
    bus.funct = 6'($urandom);
    for (int k = 0; k < 5; k++) begin
      bus.zero = 1'($urandom);
      @(negedge clk);
      got = obs();
      exp = model_vec(6'h23, bus.funct, bus.zero, k);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL lw k=%0d got=%h exp=%h", k, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    logic [15:0] got, exp;
    logic [5:0] fns [4] = '{6'h22, 6'h2a, 6'h24, 6'h25};
    foreach (fns[j]) begin
      bus.op = 6'h00;
      bus.funct = fns[j];
      for (int k = 0; k < 4; k++) begin
        bus.zero = 1'($urandom);
        @(negedge clk);
        got = obs();
        exp = model_vec(6'h00, fns[j], bus.zero, k);
        n_checks++;
        if (got !== exp) begin
          n_errors++;
          $display("FAIL rtype fn=%h k=%0d got=%h exp=%h",
                   fns[j], k, got, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] got, exp;
    logic [5:0] ops [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
    logic       zs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    foreach (ops[j]) begin
      bus.op = ops[j];
      bus.zero = zs[j];
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        got = obs();
        exp = model_vec(ops[j], bus.funct, zs[j], k);
        n_checks++;
        if (got !== exp) begin
          n_errors++;
          $display("FAIL branch op=%h z=%0d k=%0d got=%h exp=%h",
                   ops[j], zs[j], k, got, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_illegal();
    logic [15:0] got, exp;
    logic [5:0] ops [2] = '{6'h3f, 6'h00};
    foreach (ops[j]) begin
      bus.op = ops[j];
      bus.funct = 6'h00;
      for (int k = 0; k < cpi(ops[j], 6'h00); k++) begin
        bus.zero = 1'($urandom);
        @(negedge clk);
        got = obs();
        exp = model_vec(ops[j], 6'h00, bus.zero, k);
        n_checks++;
        if (got !== exp) begin
          n_errors++;
          $display("FAIL illegal op=%h k=%0d got=%h exp=%h",
                   ops[j], k, got, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] got, exp;
    bus.op = 6'h23;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) reset_n = 1'b0;
      @(negedge clk);
      got = obs();
      exp = model_vec(6'h23, bus.funct, bus.zero, k);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL rstmid lw k=%0d got=%h exp=%h", k, got, exp);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 1) reset_n = 1'b1;
      @(negedge clk);
      got = obs();
      n_checks++;
      if (got !== RST_VEC) begin
        n_errors++;
        $display("FAIL rstmid hold i=%0d got=%h exp=%h",
                 i, got, RST_VEC);
      end
      @(posedge clk); #1;
    end
    bus.op = 6'h02;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got = obs();
      exp = model_vec(6'h02, bus.funct, bus.zero, k);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL rstmid j k=%0d got=%h exp=%h", k, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump_imm();
    logic [15:0] got, exp;
    logic [5:0] ops [4] = '{6'h02, 6'h08, 6'h0a, 6'h2b};
    foreach (ops[j]) begin
      bus.op = ops[j];
      bus.funct = 6'($urandom);
      for (int k = 0; k < cpi(ops[j], bus.funct); k++) begin
        bus.zero = 1'($urandom);
        @(negedge clk);
        got = obs();
        exp = model_vec(ops[j], bus.funct, bus.zero, k);
        n_checks++;
        if (got !== exp) begin
          n_errors++;
          $display("FAIL jimm op=%h k=%0d got=%h exp=%h",
                   ops[j], k, got, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    logic [5:0] ops [10] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05,
                             6'h08, 6'h0a, 6'h02, 6'h3f, 6'h11};
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a,
                            6'h07};
    logic [5:0] op, fn;
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                        : fns[$urandom_range(0, 5)];
      bus.op = op;
      bus.funct = fn;
      for (int k = 0; k < cpi(op, fn); k++) begin
        bus.zero = 1'($urandom);
        @(negedge clk);
        got = obs();
        exp = model_vec(op, fn, bus.zero, k);
        n_checks++;
        if (got !== exp) begin
          n_errors++;
          $display("FAIL random op=%h fn=%h k=%0d got=%h exp=%h",
                   op, fn, k, got, exp);
        end
        n_checks++;
        if ($countones({bus.memwrite, bus.regwrite, bus.irwrite}) > 1)
        begin
          n_errors++;
          $display("FAIL onehot op=%h k=%0d got=%b exp=<=1 set",
                   op, k, {bus.memwrite, bus.regwrite, bus.irwrite});
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.op = 6'h00;
    bus.funct = 6'h00;
    bus.zero = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_lw();
    test_rtype();
    test_branch();
    test_illegal();
    test_reset_midflight();
    test_jump_imm();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
